// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, parametrised ALU. It sits between register-file read and
// writeback. Single-cycle ops load the output register on the accept edge.
// MUL is a shift-and-add loop that retires one multiplier bit per cycle, which
// gives a latency of WIDTH cycles.
//
// Ports:
//   i_clk, i_rst_n        clock and synchronous active-low reset
//   i_valid / o_ready     input channel: i_alu_op, i_in1 (A), i_in2 (B)
//   o_valid / i_out_ready output channel: o_alu_out plus flags o_z, o_c, o_n
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_alu_out,
  output logic             o_z,
  output logic             o_c,
  output logic             o_n
);

  typedef enum logic [2:0] {
    OP_PASS = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3,
    OP_AND  = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_SHL = 3'd7
  } op_t;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [2*WIDTH-1:0] a_q, a_d;     // multiplicand, widened so it can shift into the high half
  logic [WIDTH-1:0] b_q, b_d;       // multiplier, consumed LSB first
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d;

  logic             accept;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic [2*WIDTH-1:0] acc_sum;

  // The output slot is free when it is empty, or when it drains on this same edge.
  assign o_ready = i_rst_n && (state_q == S_IDLE) && (!valid_q || i_out_ready);
  assign accept  = i_valid && o_ready;

  assign sum_w   = {1'b0, i_in1} + {1'b0, i_in2};
  assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

  // Single-cycle datapath, evaluated directly on the incoming operands.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first; without one, a path that skips the assignment infers a latch.
    sc_res = '0;
    sc_c   = 1'b0;
    case (op_t'(i_alu_op))
      OP_PASS: sc_res = i_in1;
      OP_ADD:  begin sc_res = sum_w[WIDTH-1:0]; sc_c = sum_w[WIDTH]; end
      OP_SUB:  begin sc_res = i_in1 - i_in2;    sc_c = (i_in1 < i_in2); end
      OP_AND:  sc_res = i_in1 & i_in2;
      OP_OR:   sc_res = i_in1 | i_in2;
      OP_XOR:  sc_res = i_in1 ^ i_in2;
      OP_SHL:  sc_res = i_in1 << i_in2[SHW-1:0];
      default: sc_res = '0;  // OP_MUL goes through the iterative path
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    // A transfer empties the slot. A load on the same edge sets it again below.
    valid_d = (valid_q && i_out_ready) ? 1'b0 : valid_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_t'(i_alu_op) == OP_MUL) begin
            a_d     = {{WIDTH{1'b0}}, i_in1};
            b_d     = i_in2;
            acc_d   = '0;
            cnt_d   = SHW'(WIDTH - 1);
            state_d = S_MUL;
          end else begin
            res_d   = sc_res;
            z_d     = (sc_res == '0);
            c_d     = sc_c;
            n_d     = sc_res[WIDTH-1];
            valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - SHW'(1);
        // The last partial product is folded in on the same edge that loads the result.
        if (cnt_q == '0) begin
          res_d   = acc_sum[WIDTH-1:0];
          z_d     = (acc_sum[WIDTH-1:0] == '0);
          c_d     = |acc_sum[2*WIDTH-1:WIDTH];
          n_d     = acc_sum[WIDTH-1];
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the operand and accumulator registers are reset too, so a multiply cut short by reset leaves no residue behind.
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples its pre-edge value.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_alu_out = res_q;
  assign o_z       = z_q;
  assign o_c       = c_q;
  assign o_n       = n_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe at WIDTH=16. Every expected value
// in this file was worked out by hand. Inputs change 1 ns after a rising edge,
// and outputs are sampled at the same point.
module tb_alu_pipe;

  localparam int WIDTH = 16;
  localparam logic [2:0] OP_PASS = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3,
                         OP_AND  = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_SHL = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] in1, in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             z, c, n;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (in_valid),
    .o_ready     (ready),
    .i_alu_op    (alu_op),
    .i_in1       (in1),
    .i_in2       (in2),
    .o_valid     (out_valid),
    .i_out_ready (out_ready),
    .o_alu_out   (alu_out),
    .o_z         (z),
    .o_c         (c),
    .o_n         (n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    in1      = a;
    in2      = b;
  endtask

  task automatic expect_result(input string tag, input logic [WIDTH-1:0] r,
                               input logic ez, input logic ec, input logic en);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out"},   32'(alu_out),   32'(r));
    check({tag, "_z"},     32'(z),         32'(ez));
    check({tag, "_c"},     32'(c),         32'(ec));
    check({tag, "_n"},     32'(n),         32'(en));
  endtask

  // Presents a MUL and holds a competing ADD on the input while the block is busy.
  // The result must appear exactly WIDTH edges after the accept edge.
  task automatic run_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] r, input logic ez, input logic ec, input logic en);
    drive(OP_MUL, a, b);
    check({tag, "_ready_pre"}, 32'(ready), 32'd1);
    tick();
    drive(OP_ADD, 16'h0001, 16'h0001);
    check({tag, "_busy_ready0"}, 32'(ready), 32'd0);
    check({tag, "_busy_valid0"}, 32'(out_valid), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      check($sformatf("%s_busy_ready%0d", tag, i), 32'(ready), 32'd0);
      check($sformatf("%s_busy_valid%0d", tag, i), 32'(out_valid), 32'd0);
    end
    tick();
    expect_result(tag, r, ez, ec, en);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = OP_PASS;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(ready),     32'd0);
    check("rst_out",   32'(alu_out),   32'd0);
    check("rst_flags", {29'd0, z, c, n}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(ready), 32'd1);

    // Back-to-back ADD and SUBs, one result per cycle
    drive(OP_ADD, 16'd10, 16'd20);
    tick();
    expect_result("add30", 16'd30, 1'b0, 1'b0, 1'b0);
    drive(OP_SUB, 16'd25, 16'd21);
    tick();
    expect_result("sub4", 16'd4, 1'b0, 1'b0, 1'b0);
    drive(OP_SUB, 16'd21, 16'd25);
    tick();
    expect_result("subneg", 16'hFFFC, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Iterative multiply; overflow; then SHL and AND
    run_mul("mul75", 16'd3, 16'd25, 16'd75, 1'b0, 1'b0, 1'b0);
    tick();
    check("mul_noextra", 32'(out_valid), 32'd0);
    run_mul("mulovf", 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0);
    drive(OP_SHL, 16'h0001, 16'h0013);
    tick();
    expect_result("shl", 16'h0008, 1'b0, 1'b0, 1'b0);
    drive(OP_AND, 16'hF0F0, 16'h0FF0);
    tick();
    expect_result("and", 16'h00F0, 1'b0, 1'b0, 1'b0);
    drive(OP_OR, 16'h1200, 16'h0034);
    tick();
    expect_result("or", 16'h1234, 1'b0, 1'b0, 1'b0);
    drive(OP_PASS, 16'h8001, 16'hFFFF);
    tick();
    expect_result("pass", 16'h8001, 1'b0, 1'b0, 1'b1);
    drive(OP_ADD, 16'hFFFF, 16'h0001);
    tick();
    expect_result("addcarry", 16'h0000, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();

    // Backpressure: the result is held, then transfer and accept share one edge
    out_ready = 1'b0;
    drive(OP_ADD, 16'h7FFF, 16'h0001);
    tick();
    expect_result("bp_add", 16'h8000, 1'b0, 1'b0, 1'b1);
    drive(OP_XOR, 16'hAAAA, 16'h0F0F);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_out%0d", i),   32'(alu_out),   32'h8000);
      check($sformatf("bp_hold_ready%0d", i), 32'(ready),     32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_up", 32'(ready), 32'd1);
    tick();
    expect_result("bp_xor", 16'hA5A5, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply
    drive(OP_MUL, 16'hFFFF, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_ready_comb", 32'(ready), 32'd0);
    tick();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_out",   32'(alu_out),   32'd0);
    check("mrst_flags", {29'd0, z, c, n}, 32'd0);
    check("mrst_ready", 32'(ready),     32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst_rel_ready", 32'(ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("mrst_nostale%0d", i), 32'(out_valid), 32'd0);
    end
    drive(OP_ADD, 16'h1234, 16'h0001);
    tick();
    expect_result("mrst_add", 16'h1235, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
